i2c_master_burst: RTL

- Parametrised successor to the single-byte I2C master/slave pair.
- Standalone I2C bus master with a programmable SCL divider, multi-byte burst reads and writes, and ACK checking with abort.
- Uses a valid/ready byte stream on the host side and open-drain-style SDA/SCL pins on the bus side.
- Sits between a host controller and the board-level I2C bus or the team's I2C slave model.

---
 rtl/i2c_master_burst.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_burst.sv
// I2C bus master: programmable SCL divider, multi-byte burst read/write, ACK checking with abort.
// Optional macro CLOCK_STRETCH_EN: SCL high phase waits for scl_i to read high.
//
// state   | meaning
// IDLE    | bus released, waiting for start
// START   | SDA falls with SCL high, then SCL falls
// ADDR    | shift {addr,rw} MSB first
// AACK    | sample slave ACK for address
// WDATA   | shift host byte MSB first (stalls at Q0 of bit 7 until wdata_valid)
// WACK    | sample slave ACK for write byte
// RDATA   | sample 8 bits from slave
// RACK    | present byte to host, drive ACK/NACK
// STOP    | SDA rises with SCL high
// DONE    | one-cycle done pulse
module i2c_master_burst #(
    parameter int    CLK_DIV   = 4,
    parameter int    MAX_BYTES = 16,
    localparam int   NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            rw,
    input  logic [6:0]      addr,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      wdata,
    input  logic            wdata_valid,
    output logic            wdata_ready,
    output logic [7:0]      rdata,
    output logic            rdata_valid,
    output logic            busy,
    output logic            done,
    output logic            ack_err,
    output logic            scl,
    input  logic            scl_i,
    output logic            sda_oe,
    input  logic            sda_i
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LD = DIV_W'(CLK_DIV - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_AACK  = 4'd3;
    localparam logic [3:0] S_WDATA = 4'd4;
    localparam logic [3:0] S_WACK  = 4'd5;
    localparam logic [3:0] S_RDATA = 4'd6;
    localparam logic [3:0] S_RACK  = 4'd7;
    localparam logic [3:0] S_STOP  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    logic [3:0]      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic [NB_W-1:0] cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic            smp_q, smp_d;
    logic            loaded_q, loaded_d;
    logic            ack_err_q, ack_err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;

    logic scl_int, sda_int, in_xfer, need_byte, stretch, freeze, tick, bit_end, smp_pt;

    always_comb begin
        scl_int = qtr_q[1];
        sda_int = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: scl_int = 1'b1;
            S_START: begin
                scl_int = ~qtr_q[1];
                sda_int = (qtr_q != 2'd0);
            end
            S_ADDR:  sda_int = ~sh_q[7];
            S_WDATA: sda_int = loaded_q && !sh_q[7];
            S_RACK:  sda_int = (cnt_q > NB_W'(1));
            S_STOP:  sda_int = (qtr_q != 2'd3);
            default: ;
        endcase
    end

    assign in_xfer     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign need_byte   = (state_q == S_WDATA) && (bit_q == 3'd7) && (qtr_q == 2'd0) && !loaded_q;
    assign wdata_ready = need_byte && wdata_valid;

`ifdef CLOCK_STRETCH_EN
    // SCL released high but a slave still holds it low: hold the quarter.
    assign stretch = (qtr_q == 2'd2) && scl_int && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stretch      = 1'b0;
`endif

    assign freeze  = (need_byte && !wdata_valid) || stretch;
    assign tick    = in_xfer && (div_q == '0) && !freeze;
    assign bit_end = tick && (qtr_q == 2'd3);
    assign smp_pt  = tick && (qtr_q == 2'd2);

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        qtr_d         = qtr_q;
        bit_d         = bit_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        rw_d          = rw_q;
        smp_d         = smp_q;
        loaded_d      = loaded_q;
        ack_err_d     = ack_err_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        if (tick) begin
            div_d = DIV_LD;
            qtr_d = qtr_q + 2'd1;
        end else if (in_xfer && !freeze) begin
            div_d = div_q - DIV_W'(1);
        end
        if (smp_pt) begin
            smp_d = sda_i;
            if (state_q == S_RDATA) sh_d = {sh_q[6:0], sda_i};
        end
        if (wdata_ready) begin
            sh_d     = wdata;
            loaded_d = 1'b1;
        end

        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_START;
                sh_d      = {addr, rw};
                cnt_d     = nbytes;
                rw_d      = rw;
                ack_err_d = 1'b0;
                div_d     = DIV_LD;
                qtr_d     = 2'd0;
            end
            S_START: if (bit_end) begin
                state_d = S_ADDR;
                bit_d   = 3'd7;
            end
            S_ADDR, S_WDATA: if (bit_end) begin
                sh_d = {sh_q[6:0], 1'b0};
                if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                else               bit_d   = bit_q - 3'd1;
            end
            S_AACK: if (bit_end) begin
                bit_d    = 3'd7;
                loaded_d = 1'b0;
                if (smp_q) begin
                    ack_err_d = 1'b1;
                    state_d   = S_STOP;
                end else if (cnt_q == '0) state_d = S_STOP;
                else                      state_d = rw_q ? S_RDATA : S_WDATA;
            end
            S_WACK: if (bit_end) begin
                bit_d    = 3'd7;
                loaded_d = 1'b0;
                if (smp_q) begin
                    ack_err_d = 1'b1;
                    state_d   = S_STOP;
                end else begin
                    cnt_d   = cnt_q - NB_W'(1);
                    state_d = (cnt_q == NB_W'(1)) ? S_STOP : S_WDATA;
                end
            end
            S_RDATA: if (bit_end) begin
                if (bit_q == 3'd0) begin
                    state_d       = S_RACK;
                    rdata_d       = sh_q;
                    rdata_valid_d = 1'b1;
                end else bit_d = bit_q - 3'd1;
            end
            S_RACK: if (bit_end) begin
                bit_d   = 3'd7;
                cnt_d   = cnt_q - NB_W'(1);
                state_d = (cnt_q == NB_W'(1)) ? S_STOP : S_RDATA;
            end
            S_STOP: if (bit_end) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            qtr_q         <= 2'd0;
            bit_q         <= 3'd0;
            sh_q          <= 8'd0;
            cnt_q         <= '0;
            rw_q          <= 1'b0;
            smp_q         <= 1'b0;
            loaded_q      <= 1'b0;
            ack_err_q     <= 1'b0;
            rdata_q       <= 8'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            qtr_q         <= qtr_d;
            bit_q         <= bit_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            rw_q          <= rw_d;
            smp_q         <= smp_d;
            loaded_q      <= loaded_d;
            ack_err_q     <= ack_err_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign scl         = scl_int;
    assign sda_oe      = sda_int;
    assign busy        = in_xfer;
    assign done        = (state_q == S_DONE);
    assign ack_err     = ack_err_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
endmodule
